// File: rtl/bf_code_loader_pkg.sv
// Shared constants and state encoding for the BF program loader.
// Command byte values and the loader FSM states live here.
package bf_code_loader_pkg;

  localparam logic [7:0] CMD_INC   = 8'h2B;
  localparam logic [7:0] CMD_DEC   = 8'h2D;
  localparam logic [7:0] CMD_LEFT  = 8'h3C;
  localparam logic [7:0] CMD_RIGHT = 8'h3E;
  localparam logic [7:0] CMD_OPEN  = 8'h5B;
  localparam logic [7:0] CMD_CLOSE = 8'h5D;
  localparam logic [7:0] CMD_TERM  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TERM,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/bf_code_loader_if.sv
// Byte stream in / code-RAM write out bundle for the loader.
// master is the upstream side, slave is the loader itself.
interface bf_code_loader_if #(
  parameter int addrSize = 9
);
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_last;
  logic                in_ready;
  logic                wr_en;
  logic [addrSize-1:0] wr_addr;
  logic [7:0]          wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bf_cmd_decode.sv
// Classifies a byte as a BF command and flags the bracket bytes.
// Purely combinational.
module bf_cmd_decode
  import bf_code_loader_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_cmd,
  output logic       is_open,
  output logic       is_close
);

  // decode the six command bytes
  always_comb begin
    is_cmd   = 1'b0;
    is_open  = 1'b0;
    is_close = 1'b0;
    unique case (data)
      CMD_INC, CMD_DEC, CMD_LEFT, CMD_RIGHT: is_cmd = 1'b1;
      CMD_OPEN: begin
        is_cmd  = 1'b1;
        is_open = 1'b1;
      end
      CMD_CLOSE: begin
        is_cmd   = 1'b1;
        is_close = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bf_code_loader.sv
// Streams a BF program into code RAM, checks brackets and size,
// writes a 0x00 terminator, then releases the core from reset.
module bf_code_loader
  import bf_code_loader_pkg::*;
#(
  parameter int addrSize = 9,
  parameter bit FILTER   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  bf_code_loader_if.slave     bus,
  output logic                core_reset_n,
  output logic                done,
  output logic                error,
  output logic [addrSize-1:0] prog_len
);

  localparam logic [addrSize-1:0] PTR_MAX = '1;

  state_t state, state_n;

  logic [addrSize-1:0] ptr, ptr_n;
  logic [addrSize-1:0] depth, depth_n;
  logic [addrSize-1:0] wr_addr_q, wr_addr_n;
  logic [addrSize-1:0] prog_len_n;
  logic [7:0]          wr_data_q, wr_data_n;
  logic                wr_en_q, wr_en_n;
  logic                run_q;

  logic is_cmd, is_open, is_close;
  logic hs, term_byte, store, last;

  bf_cmd_decode u_dec (
    .data     (bus.in_data),
    .is_cmd   (is_cmd),
    .is_open  (is_open),
    .is_close (is_close)
  );

  // a restart pulse wins over any byte offered in the same cycle
  assign bus.in_ready = (state == ST_LOAD) & ~load_start;
  assign hs           = bus.in_valid & bus.in_ready;
  assign term_byte    = (bus.in_data == CMD_TERM);
  assign store        = ~term_byte & (is_cmd | ~FILTER);
  assign last         = bus.in_last | term_byte;

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign core_reset_n = run_q;
  assign done         = run_q;
  assign error        = (state == ST_ERR);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // pointer, depth, delayed write port and core release
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr       <= '0;
      depth     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      prog_len  <= '0;
      run_q     <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      depth     <= depth_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      prog_len  <= prog_len_n;
      run_q     <= (state == ST_RUN) & ~load_start;
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    depth_n    = depth;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr_q;
    wr_data_n  = wr_data_q;
    prog_len_n = prog_len;
    if (load_start) begin
      state_n = ST_LOAD;
      ptr_n   = '0;
      depth_n = '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (hs) begin
            if (store && ptr == PTR_MAX) begin
              state_n = ST_ERR;
            end else if (store && is_close && depth == '0) begin
              state_n = ST_ERR;
            end else begin
              if (store) begin
                wr_en_n   = 1'b1;
                wr_addr_n = ptr;
                wr_data_n = bus.in_data;
                ptr_n     = ptr + 1'b1;
                if (is_open)       depth_n = depth + 1'b1;
                else if (is_close) depth_n = depth - 1'b1;
              end
              if (last) begin
                state_n = (depth_n != '0) ? ST_ERR : ST_TERM;
              end
            end
          end
        end
        ST_TERM: begin
          wr_en_n    = 1'b1;
          wr_addr_n  = ptr;
          wr_data_n  = CMD_TERM;
          prog_len_n = ptr;
          state_n    = ST_RUN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_code_loader.sv
// Randomised self-checking bench for bf_code_loader.
// Two instances: addrSize 9 with filtering, addrSize 3 storing all bytes.
module tb_bf_code_loader;

  logic       clk = 0;
  logic       reset = 0;
  logic       ls9 = 0;
  logic       ls3 = 0;
  logic       in_valid = 0;
  logic       in_last = 0;
  logic [7:0] in_data = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bf_code_loader_if #(.addrSize(9)) bus9 ();
  bf_code_loader_if #(.addrSize(3)) bus3 ();

  assign bus9.in_valid = in_valid;
  assign bus9.in_data  = in_data;
  assign bus9.in_last  = in_last;
  assign bus3.in_valid = in_valid;
  assign bus3.in_data  = in_data;
  assign bus3.in_last  = in_last;

  logic       crn9, dn9, er9, crn3, dn3, er3;
  logic [8:0] pl9;
  logic [2:0] pl3;

  bf_code_loader #(.addrSize(9), .FILTER(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (ls9),
    .bus          (bus9),
    .core_reset_n (crn9),
    .done         (dn9),
    .error        (er9),
    .prog_len     (pl9)
  );

  bf_code_loader #(.addrSize(3), .FILTER(1'b0)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .load_start   (ls3),
    .bus          (bus3),
    .core_reset_n (crn3),
    .done         (dn3),
    .error        (er3),
    .prog_len     (pl3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         sel = 0;
  logic       rdy, w_en, crn, dn, er;
  logic [8:0] w_addr, plen;
  logic [7:0] w_data;

  always_comb begin
    if (sel == 0) begin
      rdy = bus9.in_ready; w_en = bus9.wr_en;
      w_addr = bus9.wr_addr; w_data = bus9.wr_data;
      crn = crn9; dn = dn9; er = er9; plen = pl9;
    end else begin
      rdy = bus3.in_ready; w_en = bus3.wr_en;
      w_addr = {6'd0, bus3.wr_addr}; w_data = bus3.wr_data;
      crn = crn3; dn = dn3; er = er3; plen = {6'd0, pl3};
    end
  end

  int   wq_addr[$], wq_data[$], wq_cyc[$], hs_cyc[$];
  int   rise_cyc = -1;
  logic crn_prev = 0;

  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      wq_addr.push_back(int'(w_addr));
      wq_data.push_back(int'(w_data));
      wq_cyc.push_back(cyc);
    end
    if (crn === 1'b1 && crn_prev !== 1'b1) rise_cyc = cyc;
    crn_prev = crn;
  end

  logic [7:0] pb[$];
  bit         pl[$];
  int         ea[$], ed[$], es[$];
  int         m_out, m_cons, m_plen;
  int         exp_plen[2] = '{0, 0};

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    hs_cyc.delete(); rise_cyc = -1;
  endtask

  task automatic set_prog(input string str, input int last_at);
    pb.delete(); pl.delete();
    for (int i = 0; i < str.len(); i++) begin
      pb.push_back(str[i]);
      pl.push_back(i == last_at);
    end
  endtask

  // reference: outcome 0=error 1=running 2=still loading
  task automatic model(input int s);
    int aw;
    bit filt;
    int depth;
    int cnt;
    bit fin;
    aw = (s == 0) ? 9 : 3;
    filt = (s == 0);
    depth = 0; cnt = 0; fin = 0;
    ea.delete(); ed.delete(); es.delete();
    m_out = 2; m_cons = 0;
    foreach (pb[i]) if (!fin) begin
      logic [7:0] b;
      bit cmd, st, lst;
      b = pb[i];
      cmd = b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D};
      st = (b != 0) && (cmd || !filt);
      lst = pl[i] || (b == 0);
      m_cons = i + 1;
      if (st && cnt == (1 << aw) - 1) begin
        m_out = 0; fin = 1;
      end else if (st && b == 8'h5D && depth == 0) begin
        m_out = 0; fin = 1;
      end else begin
        if (st) begin
          ea.push_back(cnt); ed.push_back(int'(b)); es.push_back(i);
          cnt++;
          if (b == 8'h5B) depth++;
          if (b == 8'h5D) depth--;
        end
        if (lst) begin
          fin = 1;
          if (depth != 0) m_out = 0;
          else begin
            m_out = 1; m_plen = cnt;
            ea.push_back(cnt); ed.push_back(0); es.push_back(-1);
          end
        end
      end
    end
  endtask

  task automatic start_load(input int s);
    sel = s;
    @(posedge clk); #1;
    if (s == 0) ls9 = 1; else ls3 = 1;
    @(posedge clk); #1;
    ls9 = 0; ls3 = 0;
    clear_mon();
  endtask

  task automatic stream(output int nacc);
    bit stalled;
    nacc = 0; stalled = 0;
    foreach (pb[i]) begin
      int gap;
      bit got, stop;
      gap = $urandom_range(0, 2);
      got = 0; stop = 0;
      in_valid = 0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1; in_data = pb[i]; in_last = pl[i];
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (rdy === 1'b1) begin got = 1; hs_cyc.push_back(cyc); break; end
        if (er === 1'b1 || dn === 1'b1) begin stop = 1; break; end
      end
      @(posedge clk); #1;
      in_valid = 0; in_last = 0;
      if (got) nacc++;
      else begin
        if (!stop) stalled = 1;
        break;
      end
    end
    checks++;
    if (stalled) begin
      errors++;
      $display("FAIL stream_stall: in_ready stuck low with no done/error after %0d bytes", nacc);
    end
  endtask

  task automatic check_load(input string nm, input int s, input int nacc);
    int n;
    repeat (5) @(posedge clk);
    @(negedge clk);
    if (m_out == 1) exp_plen[s] = m_plen;
    checks++;
    if (nacc != m_cons) begin
      errors++;
      $display("FAIL %s accepted: got %0d want %0d", nm, nacc, m_cons);
    end
    checks++;
    if (wq_addr.size() != ea.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", nm, wq_addr.size(), ea.size());
    end
    n = (wq_addr.size() < ea.size()) ? wq_addr.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wq_addr[i] != ea[i] || wq_data[i] != ed[i]) begin
        errors++;
        $display("FAIL %s write%0d: got a=%0d d=%02h want a=%0d d=%02h",
                 nm, i, wq_addr[i], wq_data[i], ea[i], ed[i]);
      end
      if (es[i] >= 0 && es[i] < hs_cyc.size()) begin
        checks++;
        if (wq_cyc[i] != hs_cyc[es[i]] + 1) begin
          errors++;
          $display("FAIL %s latency%0d: got cyc %0d want %0d",
                   nm, i, wq_cyc[i], hs_cyc[es[i]] + 1);
        end
      end
      if (es[i] < 0) begin
        checks++;
        if (rise_cyc != wq_cyc[i] + 1) begin
          errors++;
          $display("FAIL %s core_release: got cyc %0d want %0d",
                   nm, rise_cyc, wq_cyc[i] + 1);
        end
      end
    end
    checks++;
    if (er !== (m_out == 0) || dn !== (m_out == 1) || crn !== (m_out == 1)) begin
      errors++;
      $display("FAIL %s status: got err=%b done=%b crn=%b want outcome %0d",
               nm, er, dn, crn, m_out);
    end
    checks++;
    if (int'(plen) != exp_plen[s]) begin
      errors++;
      $display("FAIL %s prog_len: got %0d want %0d", nm, plen, exp_plen[s]);
    end
  endtask

  task automatic do_load(input string nm, input int s);
    int nacc;
    start_load(s);
    model(s);
    stream(nacc);
    check_load(nm, s, nacc);
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if (rdy !== 0 || w_en !== 0 || w_addr !== 0 || w_data !== 0 ||
        crn !== 0 || dn !== 0 || er !== 0 || plen !== 0) begin
      errors++;
      $display("FAIL %s: got rdy=%b we=%b wa=%0d wd=%02h crn=%b done=%b err=%b len=%0d want all 0",
               nm, rdy, w_en, w_addr, w_data, crn, dn, er, plen);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check_idle_outputs(s == 0 ? "reset9" : "reset3");
    end
    @(posedge clk); #1;
    reset = 1;
    sel = 0;
  endtask

  task automatic test_basic();
    set_prog("+[->+<]", 6);
    do_load("basic", 0);
  endtask

  task automatic test_restart();
    sel = 0;
    @(posedge clk); #1;
    in_valid = 1; in_data = 8'h2B; in_last = 0; ls9 = 1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL restart_run_accept: got in_ready=%b want 0", rdy);
    end
    @(posedge clk); #1;
    in_data = 8'h3E;
    @(negedge clk);
    checks++;
    if (crn !== 0 || dn !== 0 || er !== 0 || rdy !== 0) begin
      errors++;
      $display("FAIL restart_state: got crn=%b done=%b err=%b rdy=%b want 0 0 0 0",
               crn, dn, er, rdy);
    end
    @(posedge clk); #1;
    ls9 = 0; in_valid = 0;
    clear_mon();
    begin
      int nacc;
      set_prog("+>", 1);
      model(0);
      stream(nacc);
      check_load("restart", 0, nacc);
    end
  endtask

  task automatic test_filter();
    set_prog("a+ b>", 4);
    do_load("filter", 0);
  endtask

  task automatic test_mismatch();
    set_prog("]+", -1);
    do_load("mismatch", 0);
  endtask

  task automatic test_overflow();
    set_prog("++++++++", -1);
    do_load("overflow", 1);
  endtask

  task automatic gen_prog();
    int len;
    len = $urandom_range(1, 12);
    pb.delete(); pl.delete();
    for (int i = 0; i < len; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 19);
      if (r < 3)       b = 8'h2B;
      else if (r < 6)  b = 8'h2D;
      else if (r < 8)  b = 8'h3C;
      else if (r < 10) b = 8'h3E;
      else if (r == 10) b = 8'h5B;
      else if (r == 11) b = 8'h5D;
      else if (r < 18) b = 8'($urandom_range(1, 255));
      else if (r == 18) b = 8'h00;
      else b = 8'h2B;
      pb.push_back(b);
      pl.push_back(i == len - 1 && $urandom_range(0, 3) != 0);
    end
    if (!pl[len - 1]) begin
      pb.push_back(8'h00);
      pl.push_back(1'b0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int s;
      s = $urandom_range(0, 1);
      gen_prog();
      do_load($sformatf("rand%0d", k), s);
    end
  endtask

  task automatic test_reset_mid();
    int nacc;
    start_load(0);
    set_prog("+>+", -1);
    stream(nacc);
    reset = 0;
    in_valid = 1; in_data = 8'h2D; in_last = 0;
    @(posedge clk); #1;
    clear_mon();
    reset = 1;
    exp_plen[0] = 0; exp_plen[1] = 0;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    repeat (4) @(negedge clk);
    checks++;
    if (wq_addr.size() != 0 || rdy !== 0) begin
      errors++;
      $display("FAIL reset_mid_writes: got %0d writes rdy=%b want 0 writes rdy=0",
               wq_addr.size(), rdy);
    end
    in_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_filter();
    test_mismatch();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_code_loader.md
BF_CODE_LOADER -- requirements
Module: bf_code_loader

Interface
REQ-001 Parameter addrSize, default 9, SHALL set the code-RAM address width.
REQ-002 Parameter FILTER, default 1, SHALL enable dropping of non-command bytes when 1.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 load_start  input  1  single-cycle pulse; begins a new program load.
REQ-006 in_valid  input  1  upstream byte valid.
REQ-007 in_data  input  8  upstream program byte.
REQ-008 in_last  input  1  qualifies in_data as final byte of program.
REQ-009 in_ready  output  1  loader accepts byte this cycle.
REQ-010 wr_en  output  1  code-RAM write strobe.
REQ-011 wr_addr  output  addrSize  code-RAM write address.
REQ-012 wr_data  output  8  code-RAM write data.
REQ-013 core_reset_n  output  1  active-low reset driven to the processor core.
REQ-014 done  output  1  program loaded, core running.
REQ-015 error  output  1  load aborted (overflow or bracket mismatch).
REQ-016 prog_len  output  addrSize  stored command count, excluding terminator.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, TERM, RUN, ERR.
REQ-018 IDLE: in_ready=0, core_reset_n=0; load_start -> LOAD, write pointer and bracket depth cleared.
REQ-019 LOAD: in_ready=1; handshake = in_valid & in_ready.
REQ-020 Command bytes are 0x2B, 0x2D, 0x3C, 0x3E, 0x5B, 0x5D; with FILTER=1 other bytes SHALL be accepted and discarded; with FILTER=0 all bytes except 0x00 SHALL be stored.
REQ-021 A stored byte SHALL appear on wr_en/wr_addr/wr_data exactly one cycle after its handshake; pointer increments by 1 per stored byte.
REQ-022 Bracket depth SHALL increment on stored 0x5B and decrement on stored 0x5D; 0x5D at depth 0 -> ERR.
REQ-023 A command byte arriving when pointer = 2^addrSize-1 SHALL not be written and -> ERR (last address reserved for terminator).
REQ-024 Handshake with in_last: after processing that byte, depth != 0 -> ERR, else -> TERM.
REQ-025 TERM: single cycle, wr_en=1, wr_data=0x00 at current pointer; prog_len latched; -> RUN.
REQ-026 RUN: core_reset_n=1 and done=1 from the cycle after the terminator write; in_ready=0.
REQ-027 ERR: error=1, core_reset_n=0, in_ready=0; held until load_start.
REQ-028 load_start in any state SHALL return to LOAD next cycle with core_reset_n=0, done=0, error=0; load_start with simultaneous in_valid SHALL not accept that byte.
REQ-029 in_data 0x00 in LOAD SHALL be treated as in_last without being stored.
REQ-030 wr_en SHALL never assert outside LOAD-delayed writes and TERM.

Reset
REQ-031 On reset=0: state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_reset_n=0, done=0, error=0, prog_len=0, depth=0.
REQ-032 Reset mid-load SHALL abandon the load with no further RAM writes.

Structure
REQ-033 Shared package SHALL hold the BF command byte constants and the loader state encoding.
REQ-034 One sub-module bf_cmd_decode (combinational: is_cmd, is_open, is_close) SHALL be instantiated.

Verification
REQ-035 Load "+[->+<]" with in_last on ']' -> RAM 0..6 = program bytes, RAM[7]=0x00, prog_len=7, core_reset_n rises 1 cycle after terminator write.
REQ-036 Load "a+ b>" FILTER=1 -> only "+>" stored at 0,1, terminator at 2, prog_len=2.
REQ-037 Load "]+" -> error=1 after ']' handshake, no RAM write for ']', core_reset_n stays 0.
REQ-038 addrSize=3, stream 8 '+' -> 7 stored, 8th triggers ERR, no write to address 7.
REQ-039 In RUN pulse load_start with in_valid=1 -> core_reset_n=0 next cycle, byte not accepted, new load starts at address 0.
REQ-040 Assert reset=0 after 3 bytes of load -> all outputs at reset values next cycle, wr_en stays 0.
